// File: rtl/simd_muland_mac_if.sv
// Handshake and data bundle for simd_muland_mac: batch control, operand beats and held result.
// The slave modport is the engine; the master modport is whatever feeds and drains it.
interface simd_muland_mac_if #(
  parameter int N_LANES   = 8,
  parameter int LANE_W    = 32,
  parameter int MAX_BATCH = 1024
);
  localparam int CNT_W = $clog2(MAX_BATCH + 1);
  localparam int BUS_W = N_LANES * LANE_W;

  logic             start_i;
  logic [1:0]       mode_i;
  logic [CNT_W-1:0] batch_len_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [BUS_W-1:0] x_i;
  logic [BUS_W-1:0] y_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [BUS_W-1:0] acc_o;
  logic             busy_o;
  logic             err_o;

  modport slave (
    input  start_i, mode_i, batch_len_i, in_valid_i, x_i, y_i, out_ready_i,
    output in_ready_o, out_valid_o, acc_o, busy_o, err_o
  );

  modport master (
    output start_i, mode_i, batch_len_i, in_valid_i, x_i, y_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc_o, busy_o, err_o
  );
endinterface

// File: rtl/simd_muland_mac.sv
// SIMD multiply/AND-accumulate engine: per-lane x*y or x&y, pipelined, reduced over a batch.
// Optional abort port enabled by defining SIMD_MULAND_MAC_ABORT_EN.
module simd_muland_mac #(
  parameter int N_LANES    = 8,
  parameter int LANE_W     = 32,
  parameter int MUL_STAGES = 3,
  parameter int MAX_BATCH  = 1024,
  localparam int CNT_W     = $clog2(MAX_BATCH + 1),
  localparam int BUS_W     = N_LANES * LANE_W
) (
  input logic clk_i,
  input logic rst_i,
`ifdef SIMD_MULAND_MAC_ABORT_EN
  input logic abort_i,
`endif
  simd_muland_mac_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             arith_q, arith_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic [MUL_STAGES-1:0] pipe_vld_q, pipe_vld_d;
  logic [MUL_STAGES-1:0] pipe_last_q, pipe_last_d;
  logic [BUS_W-1:0] pipe_data_q [MUL_STAGES];
  logic [BUS_W-1:0] pipe_data_d [MUL_STAGES];

  logic [BUS_W-1:0] prod;
  logic [BUS_W-1:0] acc_next;
  logic             in_ready;
  logic             accept;
  logic             last_beat;
  logic             start_ok;

  assign in_ready  = (state_q == S_RUN) && (cnt_q < len_q);
  assign accept    = in_ready && bus.in_valid_i;
  assign last_beat = (cnt_q + CNT_W'(1)) == len_q;
  assign start_ok  = (bus.batch_len_i != '0) &&
                     (bus.batch_len_i <= CNT_W'(MAX_BATCH)) &&
                     ((bus.mode_i == 2'b01) || (bus.mode_i == 2'b10));

  // Lane slicing keeps every carry inside its own LANE_W field.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    prod     = '0;
    acc_next = '0;
    for (int k = 0; k < N_LANES; k++) begin
      prod[k*LANE_W +: LANE_W] = arith_q
        ? bus.x_i[k*LANE_W +: LANE_W] * bus.y_i[k*LANE_W +: LANE_W]
        : bus.x_i[k*LANE_W +: LANE_W] & bus.y_i[k*LANE_W +: LANE_W];
      acc_next[k*LANE_W +: LANE_W] = arith_q
        ? acc_q[k*LANE_W +: LANE_W] + pipe_data_q[MUL_STAGES-1][k*LANE_W +: LANE_W]
        : acc_q[k*LANE_W +: LANE_W] ^ pipe_data_q[MUL_STAGES-1][k*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    arith_d        = arith_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    err_d          = 1'b0;
    pipe_vld_d[0]  = accept;
    pipe_last_d[0] = accept && last_beat;
    pipe_data_d[0] = prod;
    for (int i = 1; i < MUL_STAGES; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (start_ok) begin
            state_d = S_RUN;
            arith_d = (bus.mode_i == 2'b01);
            len_d   = bus.batch_len_i;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) cnt_d = cnt_q + CNT_W'(1);
        if (pipe_vld_q[MUL_STAGES-1]) begin
          acc_d = acc_next;
          if (pipe_last_q[MUL_STAGES-1]) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SIMD_MULAND_MAC_ABORT_EN
    // Abort outranks both the accumulate step and a pending output handshake.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      pipe_vld_d  = '0;
      pipe_last_d = '0;
      acc_d       = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      arith_q     <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      arith_q     <= arith_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
    end
  end

  // NOTE: the product data registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    pipe_data_q <= pipe_data_d;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.acc_o       = acc_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.err_o       = err_q;

endmodule
